paralelo_serial_tx: RTL and testbench

Serializing transmitter that sits directly upstream of the receiver stage and produces its `data_out` serial stream. It accepts one 8-bit word every 8 cycles of `clk_32f` and shifts it out MSB-first. After reset it emits `SYNC_FRAMES` COM symbols so the downstream receiver can align and go active. It then sends payload bytes, or the IDLE symbol when no valid byte is offered.

---
 rtl/paralelo_serial_tx_if.sv | 26 ++
 rtl/paralelo_serial_tx.sv | 64 ++++++
 tb/tb_paralelo_serial_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_tx_if.sv
// Parallel-side handshake and serial output of the serializing transmitter.
// Handshake: ready is high for one cycle per frame; data_in/valid_in are taken
// on the rising edge that ends a ready cycle and ignored in every other cycle.
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;
  logic       active;
  logic       data_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready,
    input  active,
    input  data_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready,
    output active,
    output data_out
  );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Serializer: after reset sends SYNC_FRAMES COM symbols, then one payload byte
// (or IDLE) every 8 clocks, MSB first.
module paralelo_serial_tx #(
  parameter logic [7:0] COM         = 8'hBC,
  parameter logic [7:0] IDLE        = 8'h7C,
  parameter int         SYNC_FRAMES = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  paralelo_serial_tx_if.slave   bus,
  output logic                  state_dbg
);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_FRAME = 4'(SYNC_FRAMES);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [3:0] frame_cnt;
  logic [7:0] next_byte;
  logic       frame_end;

  assign frame_end = (bit_cnt == 3'd7);
  assign next_byte = bus.valid_in ? bus.data_in : IDLE;

  // frame_cnt saturates at LAST_FRAME, so ready stays valid in every RUN frame
  assign bus.ready  = frame_end && (frame_cnt == LAST_FRAME);
  assign bus.active = (state == RUN);
  assign state_dbg  = state;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state        <= SYNC;
      shreg        <= COM;
      bit_cnt      <= 3'd0;
      frame_cnt    <= 4'd1;
      bus.data_out <= 1'b0;
    end else begin
      bus.data_out <= shreg[3'd7 - bit_cnt];
      bit_cnt      <= bit_cnt + 3'd1;
      if (frame_end) begin
        case (state)
          SYNC: begin
            if (frame_cnt < LAST_FRAME) begin
              shreg     <= COM;
              frame_cnt <= frame_cnt + 4'd1;
            end else begin
              shreg <= next_byte;
              state <= RUN;
            end
          end
          RUN:     shreg <= next_byte;
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: default build plus a SYNC_FRAMES=1 build
// run side by side from the same clock and reset.
module tb_paralelo_serial_tx;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic clk_32f;
  logic reset;
  logic state_dbg0;
  logic state_dbg1;

  paralelo_serial_tx_if bus0 ();
  paralelo_serial_tx_if bus1 ();

  paralelo_serial_tx #(.COM(COM), .IDLE(IDLE), .SYNC_FRAMES(4)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .bus       (bus0),
    .state_dbg (state_dbg0)
  );

  paralelo_serial_tx #(.COM(COM), .IDLE(IDLE), .SYNC_FRAMES(1)) dut1 (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .bus       (bus1),
    .state_dbg (state_dbg1)
  );

  // clock / reset
  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  int n_total = 0;
  int n_bad   = 0;
  int k       = 0;            // edges since reset release
  logic [7:0] exp_q[$];       // frames expected on dut data_out
  logic [7:0] cur_exp = 8'h00;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  // one clock edge; v/d are presented only when the coming edge is a capture edge
  task automatic step(input logic v, input logic [7:0] d, output logic cap);
    int kn;
    int pos;
    logic [7:0] b1;
    kn  = k + 1;
    cap = (kn % 8 == 0) && (kn >= 32);
    if (cap) begin
      bus0.valid_in = v;
      bus0.data_in  = d;
      exp_q.push_back(v ? d : IDLE);
    end else begin
      bus0.valid_in = 1'($urandom_range(0, 1));
      bus0.data_in  = 8'($urandom_range(0, 255));
    end
    check("ready", {7'd0, bus0.ready}, {7'd0, cap});
    check("ready_sf1", {7'd0, bus1.ready}, {7'd0, (kn % 8 == 0)});
    @(posedge clk_32f);
    #1;
    k   = kn;
    pos = (k - 1) % 8;
    if (pos == 0) begin
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 8'd1, 8'd0);
        cur_exp = 8'h00;
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    check("data_out", {7'd0, bus0.data_out}, {7'd0, cur_exp[7-pos]});
    check("active", {7'd0, bus0.active}, {7'd0, (k >= 32)});
    check("state_dbg", {7'd0, state_dbg0}, {7'd0, (k >= 32)});
    b1 = (k <= 8) ? COM : IDLE;
    check("data_out_sf1", {7'd0, bus1.data_out}, {7'd0, b1[7-pos]});
    check("active_sf1", {7'd0, bus1.active}, {7'd0, (k >= 8)});
  endtask

  task automatic send_frame(input logic v, input logic [7:0] d);
    logic cap;
    int n;
    n   = 0;
    cap = 1'b0;
    while (!cap && n < 40) begin
      step(v, d, cap);
      n++;
    end
    if (!cap) check("capture_timeout", 8'd1, 8'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      bus0.valid_in = 1'($urandom_range(0, 1));
      bus0.data_in  = 8'($urandom_range(0, 255));
      @(posedge clk_32f);
      #1;
      check("rst_data_out", {7'd0, bus0.data_out}, 8'd0);
      check("rst_active", {7'd0, bus0.active}, 8'd0);
      check("rst_ready", {7'd0, bus0.ready}, 8'd0);
      check("rst_data_out_sf1", {7'd0, bus1.data_out}, 8'd0);
      check("rst_active_sf1", {7'd0, bus1.active}, 8'd0);
    end
    reset = 1'b0;
    k = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(COM);
  endtask

  initial begin
    logic cap;
    reset         = 1'b1;
    bus0.valid_in = 1'b0;
    bus0.data_in  = 8'h00;
    bus1.valid_in = 1'b0;
    bus1.data_in  = 8'h00;

    do_reset(2);

    // sync then four IDLE frames
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'h00);

    send_frame(1'b1, 8'hA5);
    send_frame(1'b1, 8'h3C);
    send_frame(1'b1, 8'hFF);

    for (int i = 0; i < 4; i++) send_frame(i % 2 == 0, 8'h12);

    // abandon a RUN byte part-way through
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, cap);
    do_reset(2);

    send_frame(1'b1, 8'h5A);
    send_frame(1'b1, 8'hC3);
    send_frame(1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, cap);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
